// File: rtl/mux4_scan_pkg.sv
// mux4_scan_pkg: shared state, width and frame definitions for the mux scan controller
package mux4_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  typedef logic [NUM_CH-1:0] frame_t;
endpackage

// File: rtl/mux4_next_ch.sv
// mux4_next_ch: lowest enabled channel overall (from_start) or lowest enabled channel above cur
module mux4_next_ch
  import mux4_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              from_start,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (mask[k] && (from_start || k > int'(cur))) begin
        nxt = SEL_W'(k);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: drives 4:1 mux selects over enabled channels, samples y into a frame, valid/ready out
// MUX4_SCAN_CONT_EN: after each frame handshake, re-latch mask/dwell and rescan without returning to IDLE
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DW = 4,
  parameter int NUM_CH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [mux4_scan_pkg::NUM_CH-1:0] ch_mask,
  input  logic [DW-1:0]                 dwell,
  input  logic                          y,
  output logic                          s1,
  output logic                          s0,
  output logic                          busy,
  output logic                          out_valid,
  output logic [mux4_scan_pkg::NUM_CH-1:0] out_data,
  input  logic                          out_ready
);
  if (NUM_CH != mux4_scan_pkg::NUM_CH) begin : g_bad_num_ch
    $error("mux4_scan_ctrl: NUM_CH must be 4");
  end
`ifdef MUX4_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DW-1:0]     cnt_q;
  logic [DW-1:0]     dwell_q;
  frame_t            mask_q;
  frame_t            frame_q;
  logic              valid_q;
  logic              from_start;
  logic              launch;
  logic              found;
  logic [SEL_W-1:0]  nxt;
  // Outside SCAN the only pick ever needed is the first channel of a fresh mask
  assign from_start = state_q != SCAN;
  assign launch = (state_q == IDLE && start) || (CONT && state_q == DONE && out_ready);
  mux4_next_ch u_next (
    .mask       (from_start ? ch_mask : mask_q),
    .cur        (sel_q),
    .from_start (from_start),
    .nxt        (nxt),
    .found      (found)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else if (launch) begin
      mask_q  <= ch_mask;
      dwell_q <= dwell;
      frame_q <= '0;
      cnt_q   <= found ? dwell : '0;
      sel_q   <= found ? nxt : sel_q;
      state_q <= found ? SCAN : DONE;
      valid_q <= !found;
    end else if (state_q == SCAN) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        frame_q[sel_q] <= y;
        cnt_q   <= found ? dwell_q : '0;
        sel_q   <= found ? nxt : sel_q;
        state_q <= found ? SCAN : DONE;
        valid_q <= !found;
      end
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end
  assign {s1, s0}  = sel_q;
  assign busy      = state_q != IDLE;
  assign out_valid = valid_q;
  assign out_data  = frame_q;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: randomized scans checked against a channel-list/latency reference model
module tb_mux4_scan_ctrl;
  logic       clk, rst, start, y, s1, s0, busy, out_valid, out_ready;
  logic [3:0] ch_mask, dwell, out_data, mux_in;
  logic [1:0] exp_sel;
  int tests = 0;
  int fails = 0;

  mux4_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .dwell(dwell), .y(y),
    .s1(s1), .s0(s0), .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  assign y = mux_in[{s1, s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests++;
    if ({s1, s0, busy, out_valid, out_data} !== 9'b0) begin
      fails++;
      $display("FAIL reset: got sel=%0d busy=%b valid=%b data=%b, want all 0", {s1, s0}, busy, out_valid, out_data);
    end
    rst = 1'b0;
    exp_sel = 2'd0;
  endtask

  // One full transaction: start, per-cycle select sequence, frame, hold under backpressure, handshake
  task automatic do_scan(input logic [3:0] m, input logic [3:0] d, input logic [3:0] iv, input int hold);
    logic [3:0] exp_data;
    exp_data = m & iv;
    mux_in = iv; ch_mask = m; dwell = d; start = 1'b1; out_ready = 1'($urandom);
    step();
    start = 1'b0; ch_mask = 4'($urandom); dwell = 4'($urandom);
    for (int c = 0; c < 4; c++)
      if (m[c]) begin
        for (int j = 0; j <= int'(d); j++) begin
          tests++;
          if ({s1, s0} !== 2'(c) || out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL scan_sel m=%b d=%0d ch%0d step%0d: got sel=%0d valid=%b busy=%b, want sel=%0d valid=0 busy=1",
                     m, d, c, j, {s1, s0}, out_valid, busy, c);
          end
          out_ready = 1'($urandom); start = 1'($urandom); ch_mask = 4'($urandom);
          step();
        end
        exp_sel = 2'(c);
      end
    out_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp_data || busy !== 1'b1 || {s1, s0} !== exp_sel) begin
        fails++;
        $display("FAIL frame m=%b d=%0d i=%b hold%0d: got valid=%b data=%b busy=%b sel=%0d, want valid=1 data=%b busy=1 sel=%0d",
                 m, d, iv, h, out_valid, out_data, busy, {s1, s0}, exp_data, exp_sel);
      end
      if (h < hold) begin
        start = 1'b1;
        step();
      end
    end
    start = 1'b0; ch_mask = m; dwell = d; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`ifdef MUX4_SCAN_CONT_EN
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL cont_busy m=%b: got busy=%b, want 1", m, busy);
    end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_sel = 2'd0;
`else
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== exp_data || {s1, s0} !== exp_sel) begin
      fails++;
      $display("FAIL handshake m=%b: got valid=%b busy=%b data=%b sel=%0d, want valid=0 busy=0 data=%b sel=%0d",
               m, out_valid, busy, out_data, {s1, s0}, exp_data, exp_sel);
    end
`endif
  endtask

  task automatic test_plan_scans();
    do_scan(4'b1111, 4'd0, 4'b1010, 0);
    do_scan(4'b0101, 4'd2, 4'b1111, 1);
    do_scan(4'b0000, 4'd3, 4'b1111, 2);
    do_scan(4'b1001, 4'd1, 4'b0110, 5);
    do_scan(4'b0010, 4'd15, 4'b0010, 0);
  endtask

  task automatic test_mid_reset();
    mux_in = 4'b1111; ch_mask = 4'b1111; dwell = 4'd2; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    tests++;
    if ({s1, s0} !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset: got sel=%0d busy=%b valid=%b data=%b, want 0 0 0 0000", {s1, s0}, busy, out_valid, out_data);
    end
    #1;
    rst = 1'b0;
    exp_sel = 2'd0;
    do_scan(4'b0110, 4'd1, 4'($urandom), 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      do_scan(4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back();
    mux_in = 4'b1000; ch_mask = 4'b1000; dwell = 4'd0; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if ({s1, s0} !== 2'd3 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got sel=%0d valid=%b, want sel=3 valid=0", {s1, s0}, out_valid);
    end
`ifdef MUX4_SCAN_CONT_EN
    for (int k = 0; k < 6; k++) begin
      step();
      tests++;
      if (out_valid !== 1'(k % 2 == 0) || {s1, s0} !== 2'd3 || busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_cont k=%0d: got valid=%b sel=%0d busy=%b, want valid=%0d sel=3 busy=1",
                 k, out_valid, {s1, s0}, busy, k % 2 == 0);
      end
    end
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
`else
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_frame: got valid=%b data=%b, want valid=1 data=1000", out_valid, out_data);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'd3) begin
        fails++;
        $display("FAIL b2b_single k=%0d: got valid=%b busy=%b sel=%0d, want valid=0 busy=0 sel=3",
                 k, out_valid, busy, {s1, s0});
      end
    end
    out_ready = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ch_mask = '0; dwell = '0; mux_in = '0; out_ready = 1'b0; exp_sel = 2'd0;
    test_reset();
    test_plan_scans();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
